// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end for the 8-bit TISC datapath.
// It owns the fetch PC, reads the synchronous program memory, and buffers each
// fetched instruction with its PC and PC+1 in a first-word-fall-through queue
// for decode. A redirect squashes everything in flight and restarts fetch.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   imem_rd_en      program-memory read strobe
//   imem_addr       program-memory read address (the current fetch PC)
//   imem_rdata      read data, valid exactly one cycle after imem_rd_en
//   redirect_valid  one-cycle pulse that flushes and restarts fetch
//   redirect_pc     restart address for redirect_valid
//   instr_valid     queue head is valid
//   instr_ready     decode takes the head entry this cycle
//   instr           head instruction (0 when the queue is empty)
//   instr_pc        PC of the head instruction (0 when empty)
//   instr_pc_next   instr_pc + 1, modulo 2^PC_W (0 when empty)
//   q_count         current queue occupancy
module if_fetch_unit #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_rd_en,
  output logic [PC_W-1:0]            imem_addr,
  input  logic [INSTR_W-1:0]         imem_rdata,
  input  logic                       redirect_valid,
  input  logic [PC_W-1:0]            redirect_pc,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [INSTR_W-1:0]         instr,
  output logic [PC_W-1:0]            instr_pc,
  output logic [PC_W-1:0]            instr_pc_next,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_OCC = (CW+1)'(DEPTH);

  // Fetch state
  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]    issue_pc_q, issue_pc_d;
  logic               inflight_q, inflight_d;

  // Queue state
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q,  count_d;
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [PC_W-1:0]    pc_mem_q    [DEPTH];

  logic               issue;
  logic               push;
  logic               pop;
  logic [CW:0]        occupancy;

  // Occupancy counts the outstanding response so a full queue can never be
  // overrun; a same-cycle pop is deliberately not credited.
  assign occupancy  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign issue      = !rst && !redirect_valid && (occupancy < DEPTH_OCC);
  assign imem_rd_en = issue;
  assign imem_addr  = fetch_pc_q;

  assign push = inflight_q && !redirect_valid;
  assign pop  = instr_valid && instr_ready && !redirect_valid;

  // Head fields read zero while the queue is empty.
  assign instr_valid   = (count_q != '0);
  assign instr         = instr_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign instr_pc      = instr_valid ? pc_mem_q[rd_ptr_q] : '0;
  assign instr_pc_next = instr_valid ? pc_mem_q[rd_ptr_q] + PC_W'(1) : '0;
  assign q_count       = count_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    issue_pc_d = issue_pc_q;
    inflight_d = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + PC_W'(1);
        issue_pc_d = fetch_pc_q;
        inflight_d = 1'b1;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= '0;
      issue_pc_q <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      issue_pc_q <= issue_pc_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage needs no reset: entries are only observed when counted.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= issue_pc_q;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_rd_en;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic [7:0]  instr_pc_next;
  logic [2:0]  q_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(.PC_W(8), .INSTR_W(16), .DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_rd_en     (imem_rd_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc_next  (instr_pc_next),
    .q_count        (q_count)
  );

  // Synchronous program memory: word[i] = 16'hA000 + i.
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= 16'hA000 + {8'h00, imem_addr};
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    rst = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 8'h00;
    imem_rdata = 16'h0000;
    repeat (2) @(negedge clk);
    #1;
    tests++; if (q_count !== 3'd0) begin fails++; $display("FAIL reset_q_count got=%0d exp=0", q_count); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_instr_valid got=%b exp=0", instr_valid); end
    tests++; if (imem_rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en got=%b exp=0", imem_rd_en); end
    tests++; if (instr !== 16'h0000) begin fails++; $display("FAIL reset_instr got=%h exp=0000", instr); end
    tests++; if (instr_pc !== 8'h00) begin fails++; $display("FAIL reset_instr_pc got=%h exp=00", instr_pc); end
    tests++; if (instr_pc_next !== 8'h00) begin fails++; $display("FAIL reset_pc_next got=%h exp=00", instr_pc_next); end
  endtask

  task automatic test_free_run;
    logic [7:0]  ea;
    logic [7:0]  ep;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      ea = 8'(i);
      tests++; if (imem_rd_en !== 1'b1) begin fails++; $display("FAIL run_rd_en cyc=%0d got=%b exp=1", i, imem_rd_en); end
      tests++; if (imem_addr !== ea) begin fails++; $display("FAIL run_addr cyc=%0d got=%h exp=%h", i, imem_addr, ea); end
      if (i < 2) begin
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL run_early_valid cyc=%0d got=%b exp=0", i, instr_valid); end
      end else begin
        ep = 8'(i - 2);
        tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL run_valid cyc=%0d got=%b exp=1", i, instr_valid); end
        tests++; if (instr !== 16'hA000 + {8'h00, ep}) begin fails++; $display("FAIL run_instr cyc=%0d got=%h exp=%h", i, instr, 16'hA000 + {8'h00, ep}); end
        tests++; if (instr_pc !== ep) begin fails++; $display("FAIL run_pc cyc=%0d got=%h exp=%h", i, instr_pc, ep); end
        tests++; if (instr_pc_next !== ep + 8'd1) begin fails++; $display("FAIL run_pc_next cyc=%0d got=%h exp=%h", i, instr_pc_next, ep + 8'd1); end
      end
    end
  endtask

  // Restart from reset with decode stalled; ends in the low phase of the first
  // cycle where q_count equals target (or reports a timeout).
  task automatic reset_and_fill(input logic [2:0] target, input string tag);
    bit found;
    @(negedge clk);
    rst = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (q_count == target) begin found = 1'b1; break; end
    end
    tests++; if (found !== 1'b1) begin fails++; $display("FAIL %s_fill_timeout q_count=%0d exp=%0d", tag, q_count, target); end
  endtask

  task automatic test_backpressure;
    reset_and_fill(3'd4, "bp");
    tests++; if (imem_rd_en !== 1'b0) begin fails++; $display("FAIL bp_full_rd_en got=%b exp=0", imem_rd_en); end
    tests++; if (instr_pc !== 8'h00) begin fails++; $display("FAIL bp_head_pc got=%h exp=00", instr_pc); end
    tests++; if (instr !== 16'hA000) begin fails++; $display("FAIL bp_head_instr got=%h exp=A000", instr); end
    @(negedge clk); #1;
    tests++; if (q_count !== 3'd4) begin fails++; $display("FAIL bp_hold_count got=%0d exp=4", q_count); end
    tests++; if (instr_pc !== 8'h00) begin fails++; $display("FAIL bp_hold_pc got=%h exp=00", instr_pc); end
    @(negedge clk);
    instr_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL bp_drain_valid k=%0d got=%b exp=1", k, instr_valid); end
      tests++; if (instr_pc !== 8'(k)) begin fails++; $display("FAIL bp_drain_pc k=%0d got=%h exp=%h", k, instr_pc, 8'(k)); end
      tests++; if (instr !== 16'hA000 + 16'(k)) begin fails++; $display("FAIL bp_drain_instr k=%0d got=%h exp=%h", k, instr, 16'hA000 + 16'(k)); end
      if (k == 0) begin
        tests++; if (imem_rd_en !== 1'b0) begin fails++; $display("FAIL bp_pop_no_credit got=%b exp=0", imem_rd_en); end
      end
      if (k == 1) begin
        tests++; if (imem_rd_en !== 1'b1 || imem_addr !== 8'h04) begin fails++; $display("FAIL bp_resume got=%b/%h exp=1/04", imem_rd_en, imem_addr); end
      end
    end
  endtask

  task automatic test_redirect_inflight;
    reset_and_fill(3'd3, "rdi");
    tests++; if (imem_rd_en !== 1'b0) begin fails++; $display("FAIL rdi_inflight_rd_en got=%b exp=0", imem_rd_en); end
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    tests++; if (q_count !== 3'd0) begin fails++; $display("FAIL rdi_count got=%0d exp=0", q_count); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rdi_valid got=%b exp=0", instr_valid); end
    tests++; if (imem_rd_en !== 1'b1 || imem_addr !== 8'h40) begin fails++; $display("FAIL rdi_issue got=%b/%h exp=1/40", imem_rd_en, imem_addr); end
    instr_ready = 1'b1;
    @(negedge clk); #1;
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rdi_squash got=%b exp=0", instr_valid); end
    @(negedge clk); #1;
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 8'h40) begin fails++; $display("FAIL rdi_first got=%b/%h exp=1/40", instr_valid, instr_pc); end
    tests++; if (instr !== 16'hA040 || instr_pc_next !== 8'h41) begin fails++; $display("FAIL rdi_first_data got=%h/%h exp=A040/41", instr, instr_pc_next); end
  endtask

  task automatic test_wrap;
    logic [7:0] ep;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 8'hFE;
    #1;
    tests++; if (imem_rd_en !== 1'b0) begin fails++; $display("FAIL wrap_redirect_rd_en got=%b exp=0", imem_rd_en); end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    tests++; if (imem_addr !== 8'hFE || instr_valid !== 1'b0) begin fails++; $display("FAIL wrap_issue got=%h/%b exp=FE/0", imem_addr, instr_valid); end
    @(negedge clk); #1;
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL wrap_gap got=%b exp=0", instr_valid); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      ep = 8'hFE + 8'(k);
      tests++; if (instr_valid !== 1'b1 || instr_pc !== ep) begin fails++; $display("FAIL wrap_pc k=%0d got=%b/%h exp=1/%h", k, instr_valid, instr_pc, ep); end
      tests++; if (instr_pc_next !== ep + 8'd1) begin fails++; $display("FAIL wrap_pc_next k=%0d got=%h exp=%h", k, instr_pc_next, ep + 8'd1); end
      tests++; if (instr !== 16'hA000 + {8'h00, ep}) begin fails++; $display("FAIL wrap_instr k=%0d got=%h exp=%h", k, instr, 16'hA000 + {8'h00, ep}); end
    end
  endtask

  task automatic test_redirect_pop_push;
    @(negedge clk); #1;
    tests++; if (q_count !== 3'd1 || instr_valid !== 1'b1) begin fails++; $display("FAIL rpp_steady got=%0d/%b exp=1/1", q_count, instr_valid); end
    redirect_valid = 1'b1; redirect_pc = 8'h80;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    tests++; if (q_count !== 3'd0 || instr_valid !== 1'b0) begin fails++; $display("FAIL rpp_flush got=%0d/%b exp=0/0", q_count, instr_valid); end
    tests++; if (imem_addr !== 8'h80) begin fails++; $display("FAIL rpp_addr got=%h exp=80", imem_addr); end
    @(negedge clk); #1;
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rpp_gap got=%b exp=0", instr_valid); end
    @(negedge clk); #1;
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 8'h80 || instr !== 16'hA080) begin fails++; $display("FAIL rpp_first got=%b/%h/%h exp=1/80/A080", instr_valid, instr_pc, instr); end
    @(negedge clk); #1;
    tests++; if (instr_pc !== 8'h81) begin fails++; $display("FAIL rpp_second got=%h exp=81", instr_pc); end
  endtask

  task automatic test_reset_mid;
    bit found;
    @(negedge clk);
    instr_ready = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (q_count == 3'd3) begin found = 1'b1; break; end
    end
    tests++; if (found !== 1'b1) begin fails++; $display("FAIL rmid_fill_timeout q_count=%0d exp=3", q_count); end
    rst = 1'b1;
    #1;
    tests++; if (imem_rd_en !== 1'b0) begin fails++; $display("FAIL rmid_rst_rd_en got=%b exp=0", imem_rd_en); end
    @(negedge clk); #1;
    tests++; if (q_count !== 3'd0 || instr_valid !== 1'b0) begin fails++; $display("FAIL rmid_cleared got=%0d/%b exp=0/0", q_count, instr_valid); end
    tests++; if (imem_rd_en !== 1'b0) begin fails++; $display("FAIL rmid_rd_en got=%b exp=0", imem_rd_en); end
    rst = 1'b0; instr_ready = 1'b1;
    #1;
    tests++; if (imem_rd_en !== 1'b1 || imem_addr !== 8'h00) begin fails++; $display("FAIL rmid_restart got=%b/%h exp=1/00", imem_rd_en, imem_addr); end
    @(negedge clk); #1;
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rmid_gap got=%b exp=0", instr_valid); end
    @(negedge clk); #1;
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 8'h00 || instr !== 16'hA000) begin fails++; $display("FAIL rmid_first got=%b/%h/%h exp=1/00/A000", instr_valid, instr_pc, instr); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_backpressure();
    test_redirect_inflight();
    test_wrap();
    test_redirect_pop_push();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
